// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack, redirect input and the valid/stall link to ID.
// master = fetch stage, slave = memory/ID/control side.
interface if_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        error_o;

    modport master (
        output imem_req_o, imem_addr_o, valid_o, instr_o, pc_o, error_o,
        input  imem_ack_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, valid_o, instr_o, pc_o, error_o,
        output imem_ack_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns PC, one outstanding imem request, FIFO_DEPTH {pc,instr} buffer; IF_MISALIGN_CHECK_EN adds misaligned-redirect halt.
// Latency: request one cycle after reset release; 0-wait ack data reaches ID next cycle, 1 instr/cycle sustained.
// Backpressure: stall_i holds the head; requests stop once buffered + in-flight entries reach FIFO_DEPTH.
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    if_fetch_if.master  bus
);
    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);

`ifdef IF_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

    state_t      state_q, state_d;
    state_t      rest_st;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] addr_q, addr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    fetch_ent_t  mem_q [FIFO_DEPTH];
    fetch_ent_t  mem_d [FIFO_DEPTH];

    logic        req, ack, redir, push, pop;
    logic [31:0] redir_tgt;

    assign req       = (state_q == REQ) || (state_q == DROP);
    assign ack       = req && bus.imem_ack_i;
    assign redir     = bus.redirect_i;
    assign push      = (state_q == REQ) && ack && !redir;
    assign pop       = (cnt_q != '0) && !bus.stall_i && !redir;
    assign redir_tgt = {bus.redirect_pc_i[31:2], 2'b00};

`ifdef IF_MISALIGN_CHECK_EN
    logic error_q, error_d;
    logic halt_pend_q, halt_pend_d;
    logic mis;

    assign mis         = redir && (bus.redirect_pc_i[1:0] != 2'b00);
    assign error_d     = error_q | mis;
    assign halt_pend_d = halt_pend_q | mis;
    // Where the FSM lands once nothing is outstanding: HALT after any misaligned redirect.
    assign rest_st     = (mis || halt_pend_q) ? HALT : IDLE;
    assign bus.error_o = error_q;
`else
    assign rest_st     = IDLE;
    assign bus.error_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mem_d      = mem_q;

        if (redir) begin
            cnt_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redir_tgt;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: fetch_pc_q, instr: bus.imem_rdata_i};
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
                fetch_pc_d      = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (pop && !push) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (redir) begin
                    state_d = rest_st;
                end else if (cnt_q < DEPTH_C) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redir) begin
                    state_d = ack ? rest_st : DROP;
                end else if (ack) begin
                    state_d = (cnt_d < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (ack) begin
                    state_d = rest_st;
                end
            end
`ifdef IF_MISALIGN_CHECK_EN
            HALT: state_d = HALT;
`endif
            default: state_d = IDLE;
        endcase

        // The request address is frozen while a request is outstanding, even across redirects.
        addr_d = (req && !ack) ? addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef IF_MISALIGN_CHECK_EN
            error_q     <= 1'b0;
            halt_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_q      <= mem_d;
`ifdef IF_MISALIGN_CHECK_EN
            error_q     <= error_d;
            halt_pend_q <= halt_pend_d;
`endif
        end
    end

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = addr_q;
    assign bus.valid_o     = (cnt_q != '0);
    assign bus.instr_o     = mem_q[rd_ptr_q].instr;
    assign bus.pc_o        = mem_q[rd_ptr_q].pc;
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table, hand-written latency/reset sequences, randomized run against a PC-stream model.
module tb_if_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory responder: acks after mem_lat wait cycles (or random 0..2), data = addr ^ mem_key.
    logic        mem_auto = 1'b1;
    logic        rand_lat = 1'b0;
    int          mem_lat  = 0;
    logic [31:0] mem_key  = 32'h0;
    logic        auto_ack = 1'b0;
    logic [31:0] auto_rdata = 32'h0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    int          wait_cnt = 0;
    int          cur_lat  = 0;

    assign bus.imem_ack_i   = mem_auto ? auto_ack : man_ack;
    assign bus.imem_rdata_i = mem_auto ? auto_rdata : man_rdata;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.imem_req_o && !rst) begin
                if (wait_cnt >= cur_lat) begin
                    auto_ack   = 1'b1;
                    auto_rdata = bus.imem_addr_o ^ mem_key;
                    wait_cnt   = 0;
                    cur_lat    = rand_lat ? int'($urandom_range(0, 2)) : mem_lat;
                end else begin
                    auto_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                auto_ack = 1'b0;
                wait_cnt = 0;
                cur_lat  = rand_lat ? int'($urandom_range(0, 2)) : mem_lat;
            end
        end
    end

    // Protocol: an unacked request must keep req and addr stable into the next cycle.
    logic        p_req, p_ack, p_rst;
    logic [31:0] p_addr;
    initial begin
        p_req = 1'b0; p_ack = 1'b0; p_rst = 1'b1; p_addr = '0;
        forever begin
            @(posedge clk);
            p_req  = bus.imem_req_o;
            p_ack  = bus.imem_ack_i;
            p_rst  = rst;
            p_addr = bus.imem_addr_o;
            @(negedge clk);
            if (p_req && !p_ack && !p_rst && !rst) begin
                chk("req held", {31'b0, bus.imem_req_o}, 32'd1);
                chk("addr held", bus.imem_addr_o, p_addr);
            end
        end
    end

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_err;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ep, input logic ee);
        vec_t v;
        v.stall = st; v.redir = rd; v.rpc = rpc;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_err = ee;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.stall_i = 1'b0;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] exp_pc;
    logic [31:0] r;
    logic [31:0] rpc;
    logic        redir_prev;
    int          delivered;
    int          seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run still active, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.stall_i = 1'b0;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst req",   {31'b0, bus.imem_req_o}, 32'd0);
        chk("rst valid", {31'b0, bus.valid_o}, 32'd0);
        chk("rst instr", bus.instr_o, 32'd0);
        chk("rst pc",    bus.pc_o, 32'd0);
        chk("rst error", {31'b0, bus.error_o}, 32'd0);

        // Streaming, stall buffering, flush on redirect, PC wrap, misaligned redirect
        add(0,0,0,              0,0,              0,0,              0);
        add(0,0,0,              1,32'h0,          0,0,              0);
        add(0,0,0,              1,32'h4,          1,32'h0,          0);
        add(0,0,0,              1,32'h8,          1,32'h4,          0);
        add(1,0,0,              1,32'hC,          1,32'h8,          0);
        add(1,0,0,              0,0,              1,32'h8,          0);
        add(1,0,0,              0,0,              1,32'h8,          0);
        add(1,0,0,              0,0,              1,32'h8,          0);
        add(1,0,0,              0,0,              1,32'h8,          0);
        add(0,0,0,              0,0,              1,32'h8,          0);
        add(0,0,0,              0,0,              1,32'hC,          0);
        add(0,0,0,              1,32'h10,         0,0,              0);
        add(0,0,0,              1,32'h14,         1,32'h10,         0);
        add(0,1,32'h200,        1,32'h18,         1,32'h14,         0);
        add(0,0,0,              0,0,              0,0,              0);
        add(0,0,0,              1,32'h200,        0,0,              0);
        add(0,1,32'hFFFF_FFFC,  1,32'h204,        1,32'h200,        0);
        add(0,0,0,              0,0,              0,0,              0);
        add(0,0,0,              1,32'hFFFF_FFFC,  0,0,              0);
        add(0,0,0,              1,32'h0,          1,32'hFFFF_FFFC,  0);
        add(0,1,32'h102,        1,32'h4,          1,32'h0,          0);
`ifdef IF_MISALIGN_CHECK_EN
        add(0,0,0,              0,0,              0,0,              1);
        add(0,0,0,              0,0,              0,0,              1);
        add(0,1,32'h300,        0,0,              0,0,              1);
        add(0,0,0,              0,0,              0,0,              1);
`else
        add(0,0,0,              0,0,              0,0,              0);
        add(0,0,0,              1,32'h100,        0,0,              0);
        add(0,0,0,              1,32'h104,        1,32'h100,        0);
`endif

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("row%0d req", i), {31'b0, bus.imem_req_o}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req)
                chk($sformatf("row%0d addr", i), bus.imem_addr_o, tbl[i].e_addr);
            chk($sformatf("row%0d valid", i), {31'b0, bus.valid_o}, {31'b0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d pc", i), bus.pc_o, tbl[i].e_pc);
                chk($sformatf("row%0d instr", i), bus.instr_o, tbl[i].e_pc);
            end
            chk($sformatf("row%0d error", i), {31'b0, bus.error_o}, {31'b0, tbl[i].e_err});
            bus.stall_i       = tbl[i].stall;
            bus.redirect_i    = tbl[i].redir;
            bus.redirect_pc_i = tbl[i].rpc;
            @(negedge clk);
        end
        bus.stall_i = 1'b0;
        bus.redirect_i = 1'b0;

        // 3-cycle memory, redirect during the wait: stale request completes, its data is dropped
        mem_lat = 3;
        do_reset();
        @(negedge clk);
        chk("lat req", {31'b0, bus.imem_req_o}, 32'd1);
        chk("lat addr", bus.imem_addr_o, 32'h0);
        @(negedge clk);
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h100;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        chk("drop req", {31'b0, bus.imem_req_o}, 32'd1);
        chk("drop addr", bus.imem_addr_o, 32'h0);
        @(negedge clk);
        chk("drop addr ack", bus.imem_addr_o, 32'h0);
        @(negedge clk);
        chk("drop idle req", {31'b0, bus.imem_req_o}, 32'd0);
        chk("drop valid", {31'b0, bus.valid_o}, 32'd0);
        @(negedge clk);
        chk("redir req addr", bus.imem_addr_o, 32'h100);
        seen = 0;
        for (int i = 0; i < 12 && !bus.valid_o; i++) @(negedge clk);
        chk("redir valid timeout", {31'b0, bus.valid_o}, 32'd1);
        chk("redir first pc", bus.pc_o, 32'h100);
        chk("redir first instr", bus.instr_o, 32'h100);

        // Reset mid-request, then a late ack while IDLE must be ignored
        do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst mid req", {31'b0, bus.imem_req_o}, 32'd0);
        mem_auto  = 1'b0;
        man_ack   = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        rst = 1'b0;
        @(negedge clk);
        man_ack = 1'b0;
        chk("late ack valid", {31'b0, bus.valid_o}, 32'd0);
        chk("late ack req", {31'b0, bus.imem_req_o}, 32'd1);
        chk("late ack addr", bus.imem_addr_o, 32'h0);
        @(negedge clk);
        chk("late ack no push", {31'b0, bus.valid_o}, 32'd0);
        mem_auto = 1'b1;

        // Random traffic vs. model: delivered PCs follow the last redirect target in +4 steps
        mem_key  = 32'h1357_9BDF;
        rand_lat = 1'b1;
        do_reset();
        exp_pc = 32'h0;
        redir_prev = 1'b0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            if (redir_prev)
                chk("flush valid", {31'b0, bus.valid_o}, 32'd0);
            bus.stall_i    = ($urandom_range(0, 9) < 3);
            bus.redirect_i = ($urandom_range(0, 29) == 0);
            r = $urandom();
            rpc = {r[31:2], 2'b00};
            if (r[0]) rpc = {28'hFFFF_FFF, r[3:2], 2'b00};
            bus.redirect_pc_i = rpc;
            if (bus.valid_o && !bus.stall_i && !bus.redirect_i) begin
                chk("rand pc", bus.pc_o, exp_pc);
                chk("rand instr", bus.instr_o, exp_pc ^ mem_key);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (bus.redirect_i) exp_pc = rpc;
            redir_prev = bus.redirect_i;
            @(negedge clk);
        end
        bus.stall_i = 1'b0;
        bus.redirect_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.valid_o) begin
                chk("drain pc", bus.pc_o, exp_pc);
                exp_pc = exp_pc + 32'd4;
                seen++;
            end
            @(negedge clk);
        end
        chk("drain progress", {31'b0, seen > 4}, 32'd1);
        chk("rand progress", {31'b0, delivered > 500}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
